// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer: bit-serial ALU between register-read and writeback.
// Takes two W-bit operands and an opcode, computes one bit per clock (LSB
// first) through a 1-bit ALU slice with a registered carry, then holds the
// assembled result and flags until the downstream stage accepts them.
module serial_alu_sequencer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [2:0]   alu_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow,
  output logic         zero,
  output logic         op_err
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  // Operation context captured at accept time
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [2:0]    r_op;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic          r_cin_msb;
  logic [W-1:0]  r_res_sh;

  // Registered outputs; they keep their values after a transfer
  logic [W-1:0]  r_result;
  logic          r_carry_out;
  logic          r_overflow;
  logic          r_zero;
  logic          r_op_err;
  logic          r_out_valid;

  // Control strobes from the output process
  logic          w_accept;
  logic          w_step;
  logic          w_finalize;
  logic          w_release;

  // Slice outputs and final flag values
  logic          w_bit_r;
  logic          w_bit_c;
  logic [W-1:0]  w_fin_result;
  logic          w_fin_carry_out;
  logic          w_fin_overflow;
  logic          w_fin_op_err;

  // 1-bit ALU slice: returns {carry_next, result_bit}. Subtract-style ops
  // feed the inverted B bit into the same full adder (carry was seeded to 1).
  function automatic logic [1:0] alu_slice(
    input logic [2:0] op,
    input logic       a,
    input logic       b,
    input logic       c
  );
    logic bb;
    logic r;
    logic cn;
    bb = ((op == OP_SUB) || (op == OP_SLTU)) ? ~b : b;
    r  = 1'b0;
    cn = c;
    case (op)
      OP_MOV:  r = a;
      OP_NOT:  r = ~a;
      OP_ADD, OP_SUB, OP_SLTU: begin
        r  = a ^ bb ^ c;
        cn = (a & bb) | (a & c) | (bb & c);
      end
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      default: r = 1'b0;
    endcase
    return {cn, r};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: W cycles in RUN, then DONE until the result is taken
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_next = S_RUN;
      S_RUN:  if (r_cnt == LAST_BIT) w_state_next = S_DONE;
      S_DONE: if (r_out_valid && out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output/control decode: first DONE cycle latches flags, later ones wait
  always_comb begin
    in_ready   = (r_state == S_IDLE);
    w_accept   = (r_state == S_IDLE) && in_valid;
    w_step     = (r_state == S_RUN);
    w_finalize = (r_state == S_DONE) && !r_out_valid;
    w_release  = (r_state == S_DONE) && r_out_valid && out_ready;
  end

  // Current bit through the slice
  always_comb begin
    {w_bit_c, w_bit_r} = alu_slice(r_op, r_a[0], r_b[0], r_carry);
  end

  // Serial datapath: operand/result shift registers, bit counter, carry
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_cin_msb <= 1'b0;
      r_res_sh  <= '0;
    end else if (w_accept) begin
      r_a       <= op_a;
      r_b       <= op_b;
      r_op      <= alu_op;
      r_cnt     <= '0;
      r_carry   <= (alu_op == OP_SUB) || (alu_op == OP_SLTU);
      r_cin_msb <= 1'b0;
      r_res_sh  <= '0;
    end else if (w_step) begin
      r_a      <= {1'b0, r_a[W-1:1]};
      r_b      <= {1'b0, r_b[W-1:1]};
      r_res_sh <= {w_bit_r, r_res_sh[W-1:1]};
      r_carry  <= w_bit_c;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == LAST_BIT) begin
        r_cin_msb <= r_carry;
      end
    end
  end

  // Final result and flags from the assembled shift register and carries
  always_comb begin
    w_fin_result    = r_res_sh;
    w_fin_carry_out = 1'b0;
    w_fin_overflow  = 1'b0;
    w_fin_op_err    = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_fin_carry_out = r_carry;
        w_fin_overflow  = r_cin_msb ^ r_carry;
      end
      OP_SUB: begin
        w_fin_carry_out = ~r_carry;
        w_fin_overflow  = r_cin_msb ^ r_carry;
      end
      OP_SLTU: begin
        w_fin_result    = {{(W-1){1'b0}}, ~r_carry};
        w_fin_carry_out = ~r_carry;
      end
      OP_MOV, OP_NOT, OP_OR, OP_AND: begin
        w_fin_result = r_res_sh;
      end
      default: begin
        w_fin_result = '0;
        w_fin_op_err = 1'b1;
      end
    endcase
  end

  // Output registers: loaded once per operation, held until the next one
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_op_err    <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_finalize) begin
      r_result    <= w_fin_result;
      r_carry_out <= w_fin_carry_out;
      r_overflow  <= w_fin_overflow;
      r_zero      <= (w_fin_result == '0);
      r_op_err    <= w_fin_op_err;
      r_out_valid <= 1'b1;
    end else if (w_release) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign op_err    = r_op_err;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// tb_serial_alu_sequencer: directed bench with an arithmetic reference model
// and a per-cycle compare process.
module tb_serial_alu_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [2:0]   alu_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         op_err;

  int errors = 0;
  int checks = 0;
  logic busy = 1'b0;
  logic [W+3:0] exp_pack = '0;   // {op_err, zero, overflow, carry_out, result}
  logic [W+3:0] got;

  always #5 clk = ~clk;

  serial_alu_sequencer #(.W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow),
    .zero(zero), .op_err(op_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the ALU must return, from plain W-bit arithmetic
  function automatic logic [W+3:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic co, ov, err;
    r = '0; co = 1'b0; ov = 1'b0; err = 1'b0;
    case (op)
      3'd0: r = a;
      3'd1: r = ~a;
      3'd2: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd3: begin
        r  = a - b;
        co = (a < b);
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd4: r = a | b;
      3'd5: r = a & b;
      3'd6: begin
        r  = (a < b) ? W'(1) : W'(0);
        co = (a < b);
      end
      default: err = 1'b1;
    endcase
    return {err, (r == '0), ov, co, r};
  endfunction

  // Every cycle: in_ready tracks busy; while out_valid, outputs match the model
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("in_ready", 32'(in_ready), 32'(!busy));
      if (out_valid) begin
        chk("result",    32'(result),    32'(exp_pack[W-1:0]));
        chk("carry_out", 32'(carry_out), 32'(exp_pack[W]));
        chk("overflow",  32'(overflow),  32'(exp_pack[W+1]));
        chk("zero",      32'(zero),      32'(exp_pack[W+2]));
        chk("op_err",    32'(op_err),    32'(exp_pack[W+3]));
      end
    end
  end

  // One transaction: accept, noise during RUN/DONE, optional stall, transfer
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, output logic [W+3:0] g);
    int edges;
    edges = 0;
    while (!in_ready && edges < 20) begin
      @(posedge clk); #1; edges++;
    end
    chk("idle_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; alu_op = op; op_a = a; op_b = b;
    @(posedge clk); #1;
    busy = 1'b1;
    exp_pack = model(op, a, b);
    edges = 0;
    while (!out_valid && edges < 40) begin
      in_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom); alu_op = 3'($urandom);
      @(posedge clk); #1; edges++;
    end
    chk("latency", 32'(edges), 32'(W + 1));
    g = {op_err, zero, overflow, carry_out, result};
    for (int i = 0; i < stall; i++) begin
      op_a = W'($urandom);
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; busy = 1'b0;
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("held_result", 32'(result), 32'(exp_pack[W-1:0]));
    $display("op=%0d a=%02h b=%02h -> result=%02h co=%0b ov=%0b z=%0b err=%0b",
             op, a, b, g[W-1:0], g[W], g[W+1], g[W+2], g[W+3]);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_in_ready"},  32'(in_ready),  32'd1);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_result"},    32'(result),    32'd0);
    chk({name, "_flags"},     32'({carry_out, overflow, zero, op_err}), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; alu_op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd2, 8'hFF, 8'h01, 0, got);
    chk("add_ff_01", 32'(got), 32'({1'b0, 1'b1, 1'b0, 1'b1, 8'h00}));
    run_op(3'd3, 8'h05, 8'h07, 5, got);
    chk("sub_05_07", 32'(got), 32'({1'b0, 1'b0, 1'b0, 1'b1, 8'hFE}));
    run_op(3'd3, 8'h80, 8'h01, 0, got);
    chk("sub_80_01", 32'(got), 32'({1'b0, 1'b0, 1'b1, 1'b0, 8'h7F}));
    run_op(3'd6, 8'h03, 8'h09, 0, got);
    chk("sltu_03_09", 32'(got), 32'({1'b0, 1'b0, 1'b0, 1'b1, 8'h01}));
    run_op(3'd6, 8'h09, 8'h03, 0, got);
    chk("sltu_09_03", 32'(got), 32'({1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));
    run_op(3'd4, 8'hA5, 8'h3C, 0, got);
    chk("or", 32'(got), 32'({4'b0000, 8'hBD}));
    run_op(3'd5, 8'hA5, 8'h3C, 2, got);
    chk("and", 32'(got), 32'({4'b0000, 8'h24}));
    run_op(3'd1, 8'hA5, 8'h3C, 0, got);
    chk("not", 32'(got), 32'({4'b0000, 8'h5A}));
    run_op(3'd0, 8'hA5, 8'h3C, 0, got);
    chk("mov", 32'(got), 32'({4'b0000, 8'hA5}));
    run_op(3'd7, 8'hA5, 8'h3C, 0, got);
    chk("op7", 32'(got), 32'({1'b1, 1'b1, 1'b0, 1'b0, 8'h00}));
    run_op(3'd2, 8'h7F, 8'h01, 3, got);
    chk("add_7f_01", 32'(got), 32'({1'b0, 1'b0, 1'b1, 1'b0, 8'h80}));
    run_op(3'd3, 8'h00, 8'h00, 0, got);
    chk("sub_00_00", 32'(got), 32'({1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));

    // Reset in the middle of an ADD, at bit count 3
    in_valid = 1'b1; alu_op = 3'd2; op_a = 8'h11; op_b = 8'h22;
    @(posedge clk); #1;
    busy = 1'b1; in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    @(posedge clk); #1;
    busy = 1'b0;
    chk_all_zero("midrun_reset");
    $display("reset at count 3 of ADD: in_ready=%0b out_valid=%0b result=%02h",
             in_ready, out_valid, result);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("aborted_no_output", 32'(out_valid), 32'd0);
    end

    run_op(3'd2, 8'h12, 8'h34, 1, got);
    chk("add_after_reset", 32'(got), 32'({4'b0000, 8'h46}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
